// File: rtl/pe_stream_decoder.sv
// -----------------------------------------------------------------------------
// pe_stream_decoder
//
// Purpose:
//   Receive side of the priority-encoder link. Encoded bit indices arrive one
//   per beat and are OR-accumulated into an N-bit one-hot vector. When a beat
//   carrying in_last is accepted, the rebuilt vector is handed downstream over
//   a valid/ready port. One completed frame can be held in the output register
//   while the next frame accumulates, so the input can run at one beat per
//   cycle as long as the consumer keeps up.
//
// Parameters:
//   N      width of the reconstructed request vector (2..16)
//   IDX_W  index width, 2**IDX_W >= N
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      decoder can accept a beat
//   in_idx     in   IDX_W  encoded bit position
//   in_last    in   1      final beat of the frame
//   in_empty   in   1      beat carries no index; in_idx ignored
//   out_valid  out  1      reconstructed frame available
//   out_ready  in   1      downstream accepts the frame
//   out_vec    out  N      reconstructed vector
//   out_err    out  1      frame had a duplicate or out-of-range index
// -----------------------------------------------------------------------------
module pe_stream_decoder #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vec,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0] acc_reg, acc_next;
  logic         acc_err_reg, acc_err_next;
  logic [N-1:0] out_vec_reg, out_vec_next;
  logic         out_err_reg, out_err_next;
  logic         out_valid_reg, out_valid_next;

  logic [N-1:0] hot;
  logic         idx_oob;
  logic         idx_dup;
  logic         beat_err;
  logic         accept;
  logic         out_free;
  logic         load_live;   // final beat goes straight to the output register
  logic         load_flush;  // a frame parked in acc moves to the output register

  // ---------------------------------------------------------------------------
  // Beat decode. Each vector bit compares against its own index, so an index
  // at or beyond N simply matches nothing and leaves hot all-zero.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_hot
      assign hot[gi] = !in_empty && (in_idx == IDX_W'(gi));
    end
  endgenerate

  // A non-empty beat that lit no bit must have been out of range.
  assign idx_oob  = !in_empty && !(|hot);
  assign idx_dup  = |(acc_reg & hot);
  assign beat_err = idx_oob || idx_dup;

  // in_ready depends only on the state, so accept is derived from the state
  // directly to keep the combinational paths free of loops.
  assign accept   = in_valid && (state_reg != FLUSH);

  // The output register can take a new frame if it is empty now, or if its
  // current frame is being consumed on this same edge.
  assign out_free = !out_valid_reg || out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!in_last) begin
            state_next = ACCUM;
          end else if (out_free) begin
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // out_valid is necessarily set here, so out_ready alone frees the
        // output register on this edge.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = (state_reg != FLUSH);
    load_live  = 1'b0;
    load_flush = 1'b0;
    case (state_reg)
      IDLE, ACCUM: load_live  = accept && in_last && out_free;
      FLUSH:       load_flush = out_ready;
      default: begin
        load_live  = 1'b0;
        load_flush = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator next value
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_next     = acc_reg;
    acc_err_next = acc_err_reg;
    if (load_flush || load_live) begin
      acc_next     = '0;
      acc_err_next = 1'b0;
    end else if (accept) begin
      // Covers both mid-frame beats and a final beat that found the output
      // register busy: in the latter case acc keeps the finished frame until
      // the FLUSH state can move it out.
      acc_next     = acc_reg | hot;
      acc_err_next = acc_err_reg | beat_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register next value
  // ---------------------------------------------------------------------------
  always_comb begin
    out_vec_next   = out_vec_reg;
    out_err_next   = out_err_reg;
    out_valid_next = out_valid_reg;
    if (load_flush) begin
      out_vec_next   = acc_reg;
      out_err_next   = acc_err_reg;
      out_valid_next = 1'b1;
    end else if (load_live) begin
      out_vec_next   = acc_reg | hot;
      out_err_next   = acc_err_reg | beat_err;
      out_valid_next = 1'b1;
    end else if (out_valid_reg && out_ready) begin
      // Data is left in place after a handshake; only valid drops.
      out_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      acc_err_reg   <= 1'b0;
      out_vec_reg   <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      acc_err_reg   <= acc_err_next;
      out_vec_reg   <= out_vec_next;
      out_err_reg   <= out_err_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_vec   = out_vec_reg;
  assign out_err   = out_err_reg;

endmodule
